// File: rtl/hcsr04_array.sv
// Round-robin multi-channel HC-SR04 ranging controller with per-channel result registers.
// Optional result smoothing enabled by defining HCSR04_ARRAY_FILTER_EN.
module hcsr04_array #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CLK_DIV       = 500,
  parameter int unsigned TRIGGER_TICKS = 1,
  parameter int unsigned MAX_COUNT     = 3800,
  parameter int unsigned HOLDOFF_TICKS = 6000,
  parameter int unsigned WIDTH         = 16,
  localparam int unsigned SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              single,
  input  logic [NUM_CH-1:0] echo,
  output logic [NUM_CH-1:0] trigger,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [WIDTH-1:0]  rd_ticks,
  output logic [NUM_CH-1:0] ch_valid,
  output logic [NUM_CH-1:0] ch_timeout,
  output logic              res_valid,
  output logic [SEL_W-1:0]  res_ch,
  output logic [WIDTH-1:0]  res_ticks,
  output logic              busy
);

  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_TOP =
      (MAX_COUNT > HOLDOFF_TICKS) ?
      ((MAX_COUNT > TRIGGER_TICKS) ? MAX_COUNT : TRIGGER_TICKS) :
      ((HOLDOFF_TICKS > TRIGGER_TICKS) ? HOLDOFF_TICKS : TRIGGER_TICKS);
  localparam int unsigned CNT_W   = $clog2(CNT_TOP + 1);

  typedef enum logic [2:0] {StIdle, StTrig, StWaitRise, StMeasure, StHoldoff} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               single_q, single_d;
  logic [DIV_W-1:0]   div_q;
  logic               tick;

  logic [NUM_CH-1:0]  sync1_q, sync2_q, prev_q, rise_q, fall_q;
  logic               echo_rise, echo_fall;

  logic               rec, rec_to;
  logic [WIDTH-1:0]   rec_ticks, store;
  logic [WIDTH-1:0]   res_q [NUM_CH];
  logic [NUM_CH-1:0]  ch_valid_q, ch_timeout_q;
  logic               res_valid_q;
  logic [SEL_W-1:0]   res_ch_q;
  logic [WIDTH-1:0]   res_ticks_q;

  // Edge pulses are registered so the FSM sees them 3 clk after the pin moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync1_q <= echo;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
      fall_q  <= prev_q & ~sync2_q;
    end
  end

  assign echo_rise = rise_q[ch_q];
  assign echo_fall = fall_q[ch_q];
  assign tick      = (div_q == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      state_q  <= StIdle;
      ch_q     <= '0;
      cnt_q    <= '0;
      single_q <= 1'b0;
    end else begin
      div_q    <= tick ? '0 : div_q + 1'b1;
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    single_d  = single_q | single;
    rec       = 1'b0;
    rec_to    = 1'b0;
    rec_ticks = '0;
    cnt_inc   = cnt_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        ch_d = '0;
        if (tick && (enable || single_q)) begin
          state_d  = StTrig;
          cnt_d    = '0;
          single_d = single;  // request consumed by this scan
        end
      end
      StTrig: begin
        if (tick) begin
          if (cnt_inc == CNT_W'(TRIGGER_TICKS)) begin
            state_d = StWaitRise;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StWaitRise: begin
        if (echo_rise) begin
          state_d = StMeasure;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_inc == CNT_W'(MAX_COUNT)) begin
            rec       = 1'b1;
            rec_to    = 1'b1;
            rec_ticks = WIDTH'(MAX_COUNT);
            state_d   = StHoldoff;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StMeasure: begin
        if (echo_fall) begin
          rec       = 1'b1;
          rec_ticks = WIDTH'(cnt_q);
          state_d   = StHoldoff;
          cnt_d     = '0;
        end else if (tick) begin
          if (cnt_inc == CNT_W'(MAX_COUNT)) begin
            rec       = 1'b1;
            rec_to    = 1'b1;
            rec_ticks = WIDTH'(MAX_COUNT);
            state_d   = StHoldoff;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StHoldoff: begin
        if (tick) begin
          if (cnt_inc == CNT_W'(HOLDOFF_TICKS)) begin
            cnt_d = '0;
            if (ch_q == SEL_W'(NUM_CH - 1)) begin
              ch_d    = '0;
              state_d = enable ? StTrig : StIdle;
            end else begin
              ch_d    = ch_q + 1'b1;
              state_d = StTrig;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef HCSR04_ARRAY_FILTER_EN
  logic [WIDTH:0] filt_sum;
  assign filt_sum = {1'b0, res_q[ch_q]} + {1'b0, rec_ticks};
  // First result and timeouts go straight in; otherwise average with the stored value.
  assign store = (rec_to || !ch_valid_q[ch_q]) ? rec_ticks : filt_sum[WIDTH:1];
`else
  assign store = rec_ticks;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CH); i++) res_q[i] <= '0;
      ch_valid_q   <= '0;
      ch_timeout_q <= '0;
      res_valid_q  <= 1'b0;
      res_ch_q     <= '0;
      res_ticks_q  <= '0;
    end else begin
      res_valid_q <= rec;
      if (rec) begin
        res_q[ch_q]        <= store;
        ch_valid_q[ch_q]   <= 1'b1;
        ch_timeout_q[ch_q] <= rec_to;
        res_ch_q           <= ch_q;
        res_ticks_q        <= store;
      end
    end
  end

  always_comb begin
    trigger = '0;
    if (state_q == StTrig) trigger[ch_q] = 1'b1;
  end

  assign busy       = (state_q != StIdle);
  assign rd_ticks   = (32'(rd_sel) < NUM_CH) ? res_q[rd_sel] : '0;
  assign ch_valid   = ch_valid_q;
  assign ch_timeout = ch_timeout_q;
  assign res_valid  = res_valid_q;
  assign res_ch     = res_ch_q;
  assign res_ticks  = res_ticks_q;

endmodule

// File: tb/tb_hcsr04_array.sv
// Self-checking bench for hcsr04_array: two sensors with modelled echo widths and a result
// scoreboard fed at each trigger end.
module tb_hcsr04_array;

  localparam int unsigned NCH  = 2;
  localparam int unsigned DIV  = 4;
  localparam int unsigned TRIG = 1;
  localparam int unsigned MAXC = 50;
  localparam int unsigned HOLD = 3;
  localparam int unsigned W    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          single = 1'b0;
  logic [1:0]    echo;
  logic [1:0]    trigger;
  logic [0:0]    rd_sel = 1'b0;
  logic [W-1:0]  rd_ticks;
  logic [1:0]    ch_valid;
  logic [1:0]    ch_timeout;
  logic          res_valid;
  logic [0:0]    res_ch;
  logic [W-1:0]  res_ticks;
  logic          busy;

  hcsr04_array #(
    .NUM_CH(NCH), .CLK_DIV(DIV), .TRIGGER_TICKS(TRIG), .MAX_COUNT(MAXC),
    .HOLDOFF_TICKS(HOLD), .WIDTH(W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .single(single), .echo(echo),
    .trigger(trigger), .rd_sel(rd_sel), .rd_ticks(rd_ticks), .ch_valid(ch_valid),
    .ch_timeout(ch_timeout), .res_valid(res_valid), .res_ch(res_ch),
    .res_ticks(res_ticks), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {int unsigned ch; int unsigned ticks; bit to;} exp_t;
  typedef struct {int w0; int w1; logic [1:0] exp_valid; logic [1:0] exp_to;} vec_t;

  int          echo_w [2];
  exp_t        sb[$];
  int          trig_seq[$];
  int unsigned model_last [2];
  bit          model_valid [2];
  int          res_count = 0;

  function automatic void check(input string name, input int act, input int req, input int tol);
    int diff;
    diff = act - req;
    checks++;
    if (diff > tol || diff < -tol) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (tol %0d)", name, act, req, tol);
    end
  endfunction

  // Echo width 0 means the sensor never answers; widths >= MAXC must saturate.
  function automatic exp_t model(input int unsigned c);
    exp_t x;
    int unsigned raw;
    x.ch = c;
    if (echo_w[c] == 0 || echo_w[c] >= int'(MAXC)) begin
      x.ticks = MAXC;
      x.to    = 1'b1;
    end else begin
      x.to = 1'b0;
      raw  = echo_w[c];
`ifdef HCSR04_ARRAY_FILTER_EN
      if (model_valid[c]) raw = (model_last[c] + raw) >> 1;
`endif
      x.ticks = raw;
    end
    model_last[c]  = x.ticks;
    model_valid[c] = 1'b1;
    return x;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_echo
    logic e = 1'b0;
    assign echo[g] = e;
    initial begin
      forever begin
        @(negedge trigger[g]);
        if (!rst && echo_w[g] != 0) begin
          repeat (3) @(posedge clk);
          #1 e = 1'b1;
          repeat (echo_w[g] * DIV) @(posedge clk);
          #1 e = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    logic [1:0] tp;
    int         tl;
    exp_t       x;
    tp = '0;
    tl = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tp = '0;
        tl = 0;
        sb.delete();
        model_valid[0] = 1'b0;
        model_valid[1] = 1'b0;
      end else begin
        if (trigger != 2'b00) begin
          tl++;
          tp = trigger;
        end else if (tp != 2'b00) begin
          check("trigger_onehot", int'($onehot(tp)), 1, 0);
          check("trigger_len", tl, DIV * TRIG, 0);
          trig_seq.push_back(tp[1] ? 1 : 0);
          sb.push_back(model(tp[1] ? 1 : 0));
          tp = '0;
          tl = 0;
        end
        if (res_valid) begin
          res_count++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got ch=%0d ticks=%0d, required no result",
                     res_ch, res_ticks);
          end else begin
            x = sb.pop_front();
            check("res_ch", int'(res_ch), x.ch, 0);
            check("res_ticks", int'(res_ticks), x.ticks, x.to ? 0 : 1);
            check("res_timeout", int'(ch_timeout[res_ch]), int'(x.to), 0);
          end
        end
      end
    end
  end

  task automatic pulse_single();
    @(posedge clk);
    #1 single = 1'b1;
    @(posedge clk);
    #1 single = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== lvl && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("busy_wait", int'(busy), int'(lvl), 0);
  endtask

  task automatic wait_echo_low();
    int n;
    n = 0;
    while (echo != 2'b00 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("echo_idle", int'(echo), 0, 0);
  endtask

  task automatic run_scan();
    pulse_single();
    wait_busy(1'b1, 40);
    wait_busy(1'b0, 3000);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_trigger"}, int'(trigger), 0, 0);
    check({tag, "_ch_valid"}, int'(ch_valid), 0, 0);
    check({tag, "_ch_timeout"}, int'(ch_timeout), 0, 0);
    check({tag, "_res_valid"}, int'(res_valid), 0, 0);
    check({tag, "_res_ch"}, int'(res_ch), 0, 0);
    check({tag, "_res_ticks"}, int'(res_ticks), 0, 0);
    check({tag, "_busy"}, int'(busy), 0, 0);
    check({tag, "_rd_ticks"}, int'(rd_ticks), 0, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin : main
    vec_t vecs [4];
    int   rc0;
    vecs[0] = '{10, 25, 2'b11, 2'b00};
    vecs[1] = '{5,  0,  2'b11, 2'b10};
    vecs[2] = '{60, 3,  2'b11, 2'b01};
    vecs[3] = '{45, 1,  2'b11, 2'b00};
    echo_w[0] = 0;
    echo_w[1] = 0;

    #1 rst = 1'b1;
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      echo_w[0] = vecs[i].w0;
      echo_w[1] = vecs[i].w1;
      trig_seq.delete();
      run_scan();
      check("scan_order_len", trig_seq.size(), 2, 0);
      if (trig_seq.size() == 2) begin
        check("scan_first_ch", trig_seq[0], 0, 0);
        check("scan_second_ch", trig_seq[1], 1, 0);
      end
      check("vec_ch_valid", int'(ch_valid), int'(vecs[i].exp_valid), 0);
      check("vec_ch_timeout", int'(ch_timeout), int'(vecs[i].exp_to), 0);
      check("vec_sb_empty", sb.size(), 0, 0);
      wait_echo_low();
    end

    rd_sel = 1'b0;
    #1 check("rd_ticks_ch0", int'(rd_ticks), int'(model_last[0]), 1);
    rd_sel = 1'b1;
    #1 check("rd_ticks_ch1", int'(rd_ticks), int'(model_last[1]), 1);
    rd_sel = 1'b0;

    // Reset in the middle of a ch0 measurement.
    echo_w[0] = 30;
    echo_w[1] = 10;
    pulse_single();
    repeat (80) @(posedge clk);
    #1 check("pre_reset_busy", int'(busy), 1, 0);
    #1 rst = 1'b1;
    #1 check_all_zero("midreset");
    @(posedge clk);
    #1 rst = 1'b0;
    wait_echo_low();
    echo_w[0] = 10;
    echo_w[1] = 20;
    trig_seq.delete();
    run_scan();
    check("post_reset_len", trig_seq.size(), 2, 0);
    if (trig_seq.size() >= 1) check("post_reset_first_ch", trig_seq[0], 0, 0);
    check("post_reset_valid", int'(ch_valid), 3, 0);

    // Enable dropped during ch0, plus a single pulse while busy.
    echo_w[0] = 8;
    echo_w[1] = 12;
    trig_seq.delete();
    rc0 = res_count;
    @(posedge clk);
    #1 enable = 1'b1;
    for (int n = 0; n < 200 && trig_seq.size() == 0; n++) @(negedge clk);
    check("enable_started", trig_seq.size(), 1, 0);
    #1 enable = 1'b0;
    pulse_single();
    wait_busy(1'b0, 3000);
    wait_busy(1'b1, 40);
    wait_busy(1'b0, 3000);
    repeat (100) @(posedge clk);
    #1 check("enable_final_busy", int'(busy), 0, 0);
    check("enable_res_count", res_count - rc0, 4, 0);
    check("enable_trig_count", trig_seq.size(), 4, 0);
    if (trig_seq.size() == 4) begin
      check("enable_seq2", trig_seq[2], 0, 0);
      check("enable_seq3", trig_seq[3], 1, 0);
    end

`ifdef HCSR04_ARRAY_FILTER_EN
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    echo_w[0] = 40;
    echo_w[1] = 5;
    run_scan();
    rd_sel = 1'b0;
    #1 check("filter_first", int'(rd_ticks), 40, 1);
    echo_w[0] = 20;
    run_scan();
    #1 check("filter_second", int'(rd_ticks), 30, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
